// File: rtl/rob_pkg.sv
// Shared reorder-buffer constants and the per-entry payload type.
// Imported by the ROB top and its pointer sub-module.
package rob_pkg;

  localparam int unsigned ROB_DEPTH = 16;
  localparam int unsigned ROB_TAG_W = $clog2(ROB_DEPTH);
  localparam int unsigned AREG_W    = 5;
  localparam int unsigned PREG_W    = 6;
  localparam int unsigned DATA_W    = 32;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              has_rd;
    logic [AREG_W-1:0] rd;
    logic [PREG_W-1:0] pd;
    logic [PREG_W-1:0] old_pd;
    logic [DATA_W-1:0] data;
  } rob_entry_t;

  localparam rob_entry_t ROB_ENTRY_CLEAR = '0;

endpackage

// File: rtl/rob_ptr.sv
// Wrapping ring pointer for the ROB head/tail; power-of-two depth wraps naturally.
// Clear is synchronous (flush); rst is asynchronous.
module rob_ptr
  import rob_pkg::*;
#(
  parameter int unsigned W = ROB_TAG_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/rob.sv
// Reorder buffer: in-order allocate from rename, out-of-order completion on two
// ports, in-order retirement exporting result data and the freed old mapping.
module rob
  import rob_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  input  logic                 alloc_has_rd,
  input  logic [AREG_W-1:0]    alloc_rd,
  input  logic [PREG_W-1:0]    alloc_pd,
  input  logic [PREG_W-1:0]    alloc_old_pd,
  output logic [ROB_TAG_W-1:0] alloc_tag,
  input  logic                 cmpl0_valid,
  input  logic [ROB_TAG_W-1:0] cmpl0_tag,
  input  logic [DATA_W-1:0]    cmpl0_data,
  input  logic                 cmpl1_valid,
  input  logic [ROB_TAG_W-1:0] cmpl1_tag,
  input  logic [DATA_W-1:0]    cmpl1_data,
  output logic                 retire_valid,
  input  logic                 retire_ready,
  output logic                 retire_has_rd,
  output logic [AREG_W-1:0]    retire_rd,
  output logic [PREG_W-1:0]    retire_pd,
  output logic [PREG_W-1:0]    retire_old_pd,
  output logic [DATA_W-1:0]    retire_data,
  output logic [ROB_TAG_W:0]   count
);

  localparam int unsigned DEPTH = ROB_DEPTH;
  localparam int unsigned TAG_W = ROB_TAG_W;
  localparam int unsigned CNT_W = TAG_W + 1;

  rob_entry_t         ent [DEPTH];
  rob_entry_t         head_ent;
  logic [TAG_W-1:0]   head;
  logic [TAG_W-1:0]   tail;
  logic               alloc_fire;
  logic               retire_fire;

  // Occupancy alone decides full; a same-cycle retire never frees a slot early.
  assign alloc_ready = count < CNT_W'(DEPTH);
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_tag   = tail;

  assign head_ent     = ent[head];
  assign retire_valid = head_ent.valid && head_ent.done;
  assign retire_fire  = retire_valid && retire_ready;

  assign retire_has_rd = retire_valid && head_ent.has_rd;
  assign retire_rd     = retire_valid ? head_ent.rd     : '0;
  assign retire_pd     = retire_valid ? head_ent.pd     : '0;
  assign retire_old_pd = retire_valid ? head_ent.old_pd : '0;
  assign retire_data   = retire_valid ? head_ent.data   : '0;

  rob_ptr #(.W(TAG_W)) u_head (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (retire_fire),
    .ptr (head)
  );

  rob_ptr #(.W(TAG_W)) u_tail (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (alloc_fire),
    .ptr (tail)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({alloc_fire, retire_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Write order matters: port 1 then port 0 so port 0 wins a tag collision,
  // and retire last so a retiring head always leaves invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= ROB_ENTRY_CLEAR;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= ROB_ENTRY_CLEAR;
    end else begin
      if (alloc_fire) begin
        ent[tail] <= '{valid:  1'b1,
                       done:   1'b0,
                       has_rd: alloc_has_rd,
                       rd:     alloc_rd,
                       pd:     alloc_pd,
                       old_pd: alloc_old_pd,
                       data:   '0};
      end
      if (cmpl1_valid && ent[cmpl1_tag].valid) begin
        ent[cmpl1_tag].done <= 1'b1;
        ent[cmpl1_tag].data <= cmpl1_data;
      end
      if (cmpl0_valid && ent[cmpl0_tag].valid) begin
        ent[cmpl0_tag].done <= 1'b1;
        ent[cmpl0_tag].data <= cmpl0_data;
      end
      if (retire_fire) begin
        ent[head].valid <= 1'b0;
        ent[head].done  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rob.sv
// Directed bench for the reorder buffer; allocations are queued as expected
// retirements and compared in order as the head retires.
module tb_rob;
  import rob_pkg::*;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              alloc_valid;
  logic              alloc_ready;
  logic              alloc_has_rd;
  logic [AREG_W-1:0] alloc_rd;
  logic [PREG_W-1:0] alloc_pd;
  logic [PREG_W-1:0] alloc_old_pd;
  logic [3:0]        alloc_tag;
  logic              cmpl0_valid, cmpl1_valid;
  logic [3:0]        cmpl0_tag, cmpl1_tag;
  logic [31:0]       cmpl0_data, cmpl1_data;
  logic              retire_valid;
  logic              retire_ready;
  logic              retire_has_rd;
  logic [AREG_W-1:0] retire_rd;
  logic [PREG_W-1:0] retire_pd;
  logic [PREG_W-1:0] retire_old_pd;
  logic [31:0]       retire_data;
  logic [4:0]        count;

  rob dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_has_rd(alloc_has_rd), .alloc_rd(alloc_rd), .alloc_pd(alloc_pd),
    .alloc_old_pd(alloc_old_pd), .alloc_tag(alloc_tag),
    .cmpl0_valid(cmpl0_valid), .cmpl0_tag(cmpl0_tag), .cmpl0_data(cmpl0_data),
    .cmpl1_valid(cmpl1_valid), .cmpl1_tag(cmpl1_tag), .cmpl1_data(cmpl1_data),
    .retire_valid(retire_valid), .retire_ready(retire_ready),
    .retire_has_rd(retire_has_rd), .retire_rd(retire_rd), .retire_pd(retire_pd),
    .retire_old_pd(retire_old_pd), .retire_data(retire_data), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] tag;
    logic       has_rd;
    logic [4:0] rd;
    logic [5:0] pd;
    logic [5:0] old_pd;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_data [16];
  bit          exp_valid [16];
  int          exp_count;
  logic [3:0]  exp_tail;
  int          passed = 0;
  int          total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    sb.delete();
    for (int i = 0; i < 16; i++) exp_valid[i] = 1'b0;
    exp_count = 0;
    exp_tail  = '0;
  endtask

  task automatic do_alloc(input logic has_rd, input logic [4:0] rd,
                          input logic [5:0] pd, input logic [5:0] old_pd);
    exp_t e;
    chk("alloc_ready", 32'(alloc_ready), 32'd1);
    chk("alloc_tag", 32'(alloc_tag), 32'(exp_tail));
    alloc_valid = 1'b1; alloc_has_rd = has_rd; alloc_rd = rd;
    alloc_pd = pd; alloc_old_pd = old_pd;
    step();
    alloc_valid = 1'b0;
    e.tag = exp_tail; e.has_rd = has_rd; e.rd = rd; e.pd = pd; e.old_pd = old_pd;
    sb.push_back(e);
    exp_valid[exp_tail] = 1'b1;
    exp_tail  = exp_tail + 4'd1;
    exp_count = exp_count + 1;
  endtask

  task automatic complete(input logic [3:0] tag, input logic [31:0] data);
    cmpl0_valid = 1'b1; cmpl0_tag = tag; cmpl0_data = data;
    step();
    cmpl0_valid = 1'b0;
    if (exp_valid[tag]) exp_data[tag] = data;
  endtask

  task automatic check_head(input exp_t e);
    chk("retire_valid", 32'(retire_valid), 32'd1);
    chk("retire_has_rd", 32'(retire_has_rd), 32'(e.has_rd));
    chk("retire_rd", 32'(retire_rd), 32'(e.rd));
    chk("retire_pd", 32'(retire_pd), 32'(e.pd));
    chk("retire_old_pd", 32'(retire_old_pd), 32'(e.old_pd));
    chk("retire_data", retire_data, exp_data[e.tag]);
  endtask

  task automatic do_retire();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      $error("FAIL retire_pop: observed empty queue expected entry");
    end else begin
      e = sb.pop_front();
      check_head(e);
      retire_ready = 1'b1;
      step();
      retire_ready = 1'b0;
      exp_valid[e.tag] = 1'b0;
      exp_count = exp_count - 1;
      chk("count_after_retire", 32'(count), 32'(exp_count));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    clear_model();
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0; alloc_has_rd = 1'b0;
    alloc_rd = '0; alloc_pd = '0; alloc_old_pd = '0;
    cmpl0_valid = 1'b0; cmpl0_tag = '0; cmpl0_data = '0;
    cmpl1_valid = 1'b0; cmpl1_tag = '0; cmpl1_data = '0;
    retire_ready = 1'b0;
    for (int i = 0; i < 16; i++) exp_data[i] = '0;
    clear_model();
    #1;
    chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    chk("rst_alloc_tag", 32'(alloc_tag), 32'd0);
    chk("rst_retire_valid", 32'(retire_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_retire_data", retire_data, 32'd0);
    chk("rst_retire_old_pd", 32'(retire_old_pd), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Three allocations, out-of-order completion, in-order retirement
    do_alloc(1'b1, 5'd1, 6'd10, 6'd1);
    do_alloc(1'b1, 5'd2, 6'd11, 6'd2);
    do_alloc(1'b1, 5'd3, 6'd12, 6'd3);
    chk("count3", 32'(count), 32'd3);
    chk("rv_none_done", 32'(retire_valid), 32'd0);
    complete(4'd1, 32'hAA);
    chk("rv_tag1_only", 32'(retire_valid), 32'd0);
    complete(4'd0, 32'h55);
    do_retire();
    do_retire();
    chk("count_end1", 32'(count), 32'd1);
    chk("rv_tag2_pending", 32'(retire_valid), 32'd0);

    // Fill to full, then a retire with a refused allocate in the same cycle
    for (int i = 0; i < 15; i++) do_alloc(1'b1, 5'(i + 4), 6'(i + 20), 6'(i + 4));
    chk("full_count", 32'(count), 32'd16);
    chk("full_ready", 32'(alloc_ready), 32'd0);
    complete(4'd2, 32'h77);
    e = sb.pop_front();
    check_head(e);
    alloc_valid = 1'b1; alloc_rd = 5'd31; alloc_pd = 6'd63; alloc_old_pd = 6'd63;
    retire_ready = 1'b1;
    step();
    alloc_valid = 1'b0; retire_ready = 1'b0;
    exp_valid[e.tag] = 1'b0;
    exp_count = exp_count - 1;
    chk("full_retire_count", 32'(count), 32'd15);
    chk("full_refused_tag", 32'(alloc_tag), 32'(exp_tail));
    while (sb.size() != 0) begin
      complete(sb[0].tag, $urandom);
      do_retire();
    end

    // Wrap-around: one instruction in flight at a time
    do_reset();
    for (int i = 0; i < 20; i++) begin
      do_alloc(1'(i % 2), 5'(i + 1), 6'(i + 30), 6'(i));
      complete(exp_tail - 4'd1, 32'(i * 3 + 1));
      chk("wrap_count", 32'(count), 32'd1);
      do_retire();
    end

    // Port 0 wins a same-tag collision; completion to an invalid tag is dropped
    do_reset();
    do_alloc(1'b1, 5'd1, 6'd10, 6'd1);
    do_alloc(1'b0, 5'd0, 6'd11, 6'd2);
    do_alloc(1'b1, 5'd3, 6'd12, 6'd3);
    cmpl0_valid = 1'b1; cmpl0_tag = 4'd2; cmpl0_data = 32'h11;
    cmpl1_valid = 1'b1; cmpl1_tag = 4'd2; cmpl1_data = 32'h22;
    step();
    cmpl0_valid = 1'b0; cmpl1_valid = 1'b0;
    exp_data[2] = 32'h11;
    complete(4'd5, 32'h99);
    chk("stray_count", 32'(count), 32'd3);
    chk("stray_rv", 32'(retire_valid), 32'd0);
    do_alloc(1'b1, 5'd4, 6'd13, 6'd4);
    do_alloc(1'b1, 5'd5, 6'd14, 6'd5);
    do_alloc(1'b1, 5'd6, 6'd15, 6'd6);
    complete(4'd0, 32'h100);
    complete(4'd1, 32'h101);
    do_retire();
    do_retire();
    do_retire();
    chk("rv_head3", 32'(retire_valid), 32'd0);
    complete(4'd3, 32'h103);
    complete(4'd4, 32'h104);
    do_retire();
    do_retire();
    chk("rv_head5_not_done", 32'(retire_valid), 32'd0);
    complete(4'd5, 32'h105);
    do_retire();

    // Flush beats a same-cycle completion, allocate and retire
    for (int i = 0; i < 5; i++) do_alloc(1'b1, 5'(i + 7), 6'(i + 40), 6'(i + 7));
    complete(4'd6, 32'h66);
    flush = 1'b1; alloc_valid = 1'b1; retire_ready = 1'b1;
    cmpl0_valid = 1'b1; cmpl0_tag = 4'd7; cmpl0_data = 32'h67;
    step();
    flush = 1'b0; alloc_valid = 1'b0; retire_ready = 1'b0; cmpl0_valid = 1'b0;
    clear_model();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_rv", 32'(retire_valid), 32'd0);
    chk("flush_tag", 32'(alloc_tag), 32'd0);
    chk("flush_ready", 32'(alloc_ready), 32'd1);
    chk("flush_data", retire_data, 32'd0);
    complete(4'd6, 32'h86);
    do_alloc(1'b1, 5'd9, 6'd50, 6'd9);
    chk("flush_new_rv", 32'(retire_valid), 32'd0);

    // Asynchronous reset mid-burst, checked before the next clock edge
    do_alloc(1'b1, 5'd10, 6'd51, 6'd10);
    do_alloc(1'b1, 5'd11, 6'd52, 6'd11);
    complete(4'd0, 32'hBEEF);
    chk("pre_rst_rv", 32'(retire_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rv", 32'(retire_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_tag", 32'(alloc_tag), 32'd0);
    chk("arst_data", retire_data, 32'd0);
    chk("arst_rd", 32'(retire_rd), 32'd0);
    #2;
    rst = 1'b0;
    clear_model();
    step();
    do_alloc(1'b1, 5'd12, 6'd53, 6'd12);
    chk("post_rst_count", 32'(count), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
